// File: rtl/seq_mul_ctrl.sv
// Iterative shift-and-add multiplier: one partial product per cycle over WIDTH cycles,
// unsigned/signed multiply and square, with valid/ready handshakes on both sides.
module seq_mul_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_b_eff;
    logic [WIDTH-1:0]     w_mcand;
    logic [WIDTH-1:0]     w_mplier;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_pp;

    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    assign w_b_eff  = op[1] ? a : b;
    assign w_mcand  = op[0] ? mag(a) : a;
    assign w_mplier = op[0] ? mag(w_b_eff) : w_b_eff;
    assign w_neg    = op[0] & ~op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_pp     = ({{WIDTH{1'b0}}, r_mcand} << r_cnt) & {(2*WIDTH){r_mplier[r_cnt]}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) w_state_next = RUN;
            end
            RUN:  if (r_cnt == LAST) w_state_next = SIGN;
            SIGN: w_state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_mcand  <= w_mcand;
                    r_mplier <= w_mplier;
                    r_neg    <= w_neg;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                RUN: begin
                    r_acc <= r_acc + w_pp;
                    // Hold at the last index so the counter never wraps.
                    if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
                end
                SIGN: r_p <= r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
                default: ;
            endcase
        end
    end

    assign p = r_p;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Scoreboarded bench for seq_mul_ctrl: directed cases, backpressure, mid-op reset
// and 1000 random operations against an integer-arithmetic reference.
module tb_seq_mul_ctrl;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic [1:0]       op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*W-1:0]   p;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    logic [2*W-1:0] exp_q[$];

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .p(p), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] o);
        longint xv, yv;
        if (o[1]) y = x;
        xv = o[0] ? longint'($signed(x)) : longint'(x);
        yv = o[0] ? longint'($signed(y)) : longint'(y);
        return (2*W)'(xv * yv);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for in_ready, presents one operand set for a single accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop,
                         input bit push, input logic [2*W-1:0] exp);
        int t = 0;
        while (!in_ready && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        a = ia; b = ib; op = iop;
        if (push) begin
            exp_q.push_back(exp);
            n_pushed++;
        end
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop,
                          input logic [2*W-1:0] exp);
        int n;
        issue(ia, ib, iop, 1'b1, exp);
        wait_out_valid(n);
        consume();
    endtask

    // Monitor: every product handed over is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_product", 1, 0);
            end else begin
                chk("product", p, exp_q.pop_front());
                n_popped++;
            end
        end
    end

    initial begin
        int n;
        int bad;
        logic [2*W-1:0] held;
        bit drv_done;

        // Reset state
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_p", p, 0);
        rst = 1'b0;

        // Unsigned 15*15 with latency measurement
        issue(4'hF, 4'hF, 2'b00, 1'b1, 8'd225);
        wait_out_valid(n);
        chk("latency", n, W + 1);
        consume();
        run_op(4'h0, 4'h9, 2'b00, 8'd0);
        run_op(4'b1000, 4'd7, 2'b01, 8'hC8);
        run_op(4'hD, 4'hB, 2'b01, 8'd15);
        run_op(4'b1000, 4'h3, 2'b11, 8'd64);
        run_op(4'hD, 4'h0, 2'b10, 8'd169);
        run_op(4'b1000, 4'b1000, 2'b01, 8'd64);
        run_op(4'hF, 4'h1, 2'b01, 8'hFF);

        // Backpressure with an ignored in_valid pulse
        issue(4'd6, 4'd7, 2'b00, 1'b1, 8'd42);
        wait_out_valid(n);
        held = p;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; a = 4'd2; b = 4'd2; op = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        chk("bp_stable", bad, 0);
        chk("bp_p", held, 8'd42);
        consume();
        chk("bp_out_valid_fall", out_valid, 0);
        chk("bp_in_ready_rise", in_ready, 1);
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        chk("bp_no_dup", bad, 0);

        // Reset in the middle of RUN
        issue(4'd9, 4'd9, 2'b00, 1'b0, '0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_p", p, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        run_op(4'd3, 4'd5, 2'b00, 8'd15);

        // Random back-to-back with random backpressure
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    logic [W-1:0] ra, rb;
                    logic [1:0] ro;
                    ra = W'($urandom); rb = W'($urandom); ro = 2'($urandom);
                    issue(ra, rb, ro, 1'b1, model(ra, rb, ro));
                end
                drv_done = 1'b1;
            end
            begin
                int t = 0;
                while (!(drv_done && exp_q.size() == 0) && t < 60000) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                    t++;
                end
                out_ready = 1'b0;
                if (t >= 60000) chk("drain_timeout", 0, 1);
            end
        join
        chk("queue_empty", exp_q.size(), 0);
        chk("ops_consumed", n_popped, n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
